// File: rtl/wmem_read_sequencer.sv
// Weight-memory read-request initiator: issues strided weight-buffer reads into the PE chain,
// repeated over a number of passes, with stall back-pressure and a busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; cfg_* latched on the start edge
// READ  | issuing reads; address held while stalled
// DONE  | one-cycle completion pulse, then back to IDLE
module wmem_read_sequencer #(
    parameter int WBUF_READ_ADDR_WIDTH = 8,
    parameter int ADDR_CNT_WIDTH       = 16,
    parameter int PASS_CNT_WIDTH       = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [WBUF_READ_ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [WBUF_READ_ADDR_WIDTH-1:0] cfg_addr_stride,
    input  logic [ADDR_CNT_WIDTH-1:0]       cfg_num_addr,
    input  logic [PASS_CNT_WIDTH-1:0]       cfg_num_passes,
    input  logic                            stall,
    output logic                            read_req_w_mem,
    output logic [WBUF_READ_ADDR_WIDTH-1:0] r_addr_w_mem,
    output logic                            busy,
    output logic                            pass_last,
    output logic                            done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [ADDR_CNT_WIDTH-1:0] ADDR_ONE = {{(ADDR_CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PASS_CNT_WIDTH-1:0] PASS_ONE = {{(PASS_CNT_WIDTH-1){1'b0}}, 1'b1};

    state_t state;
    state_t state_next;

    logic [WBUF_READ_ADDR_WIDTH-1:0] base_reg;
    logic [WBUF_READ_ADDR_WIDTH-1:0] stride_reg;
    logic [ADDR_CNT_WIDTH-1:0]       num_addr_reg;
    logic [PASS_CNT_WIDTH-1:0]       num_passes_reg;

    logic [WBUF_READ_ADDR_WIDTH-1:0] addr_reg;
    logic [WBUF_READ_ADDR_WIDTH-1:0] addr_next;
    logic [ADDR_CNT_WIDTH-1:0]       addr_cnt;
    logic [ADDR_CNT_WIDTH-1:0]       addr_cnt_next;
    logic [PASS_CNT_WIDTH-1:0]       pass_cnt;
    logic [PASS_CNT_WIDTH-1:0]       pass_cnt_next;

    logic cfg_load;
    logic last_addr;
    logic last_pass;

    // Counters only ever run 0..N-1, so an equality test against N-1 suffices.
    assign last_addr = (addr_cnt == num_addr_reg - ADDR_ONE);
    assign last_pass = (pass_cnt == num_passes_reg - PASS_ONE);

    assign r_addr_w_mem = addr_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            base_reg       <= '0;
            stride_reg     <= '0;
            num_addr_reg   <= '0;
            num_passes_reg <= '0;
            addr_reg       <= '0;
            addr_cnt       <= '0;
            pass_cnt       <= '0;
        end else begin
            state    <= state_next;
            addr_reg <= addr_next;
            addr_cnt <= addr_cnt_next;
            pass_cnt <= pass_cnt_next;
            if (cfg_load) begin
                base_reg       <= cfg_base_addr;
                stride_reg     <= cfg_addr_stride;
                num_addr_reg   <= cfg_num_addr;
                num_passes_reg <= cfg_num_passes;
            end
        end
    end

    always_comb begin
        state_next     = state;
        addr_next      = addr_reg;
        addr_cnt_next  = addr_cnt;
        pass_cnt_next  = pass_cnt;
        cfg_load       = 1'b0;
        read_req_w_mem = 1'b0;
        busy           = 1'b0;
        pass_last      = 1'b0;
        done           = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    cfg_load      = 1'b1;
                    addr_next     = cfg_base_addr;
                    addr_cnt_next = '0;
                    pass_cnt_next = '0;
                    if (cfg_num_addr == '0 || cfg_num_passes == '0) begin
                        state_next = DONE;
                    end else begin
                        state_next = READ;
                    end
                end
            end

            READ: begin
                busy           = 1'b1;
                pass_last      = last_pass;
                read_req_w_mem = !stall;
                if (!stall) begin
                    if (!last_addr) begin
                        addr_cnt_next = addr_cnt + ADDR_ONE;
                        addr_next     = addr_reg + stride_reg;
                    end else if (!last_pass) begin
                        // Next pass begins on the following cycle without a bubble.
                        pass_cnt_next = pass_cnt + PASS_ONE;
                        addr_cnt_next = '0;
                        addr_next     = base_reg;
                    end else begin
                        state_next = DONE;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
